// File: rtl/kbd_io_pkg.sv
// Shared types and constants for the memory-mapped PS/2 keyboard slave.
package kbd_io_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  // STATUS read layout: {26'b0, perr, ovf, count[3:0]}
  localparam int ST_OVF_BIT  = 4;
  localparam int ST_PERR_BIT = 5;

  // STATUS write: set bits clear the matching sticky flag
  localparam int CLR_OVF_BIT  = 0;
  localparam int CLR_PERR_BIT = 1;

  typedef enum logic {B_IDLE, B_ACK} bus_state_t;

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_PARITY, R_STOP} rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge detect, frame FSM and inactivity timeout.
// Odd-parity checking is compiled in only when KBD_PARITY_CHECK_EN is defined.
module ps2_rx
  import kbd_io_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_vld,
  output logic       par_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]  clk_sync, data_sync;
  logic        clk_prev;
  logic        fall, bit_in, timeout;
  rx_state_t   state_q, state_d;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [TW-1:0] timer;
`ifdef KBD_PARITY_CHECK_EN
  logic        parity_q;
  logic        par_ok;
  assign par_ok = ^{parity_q, shift};
`endif

  assign fall    = clk_prev & ~clk_sync[1];
  assign bit_in  = data_sync[1];
  assign timeout = (state_q != R_IDLE) && (timer == TW'(TIMEOUT - 1));
  assign code    = shift;

  // NOTE: defaults are assigned first so every path drives every output and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    code_vld = 1'b0;
    par_err  = 1'b0;
    if (fall) begin
      case (state_q)
        R_IDLE:   if (!bit_in) state_d = R_DATA;
        R_DATA:   if (bit_cnt == 3'd7) state_d = R_PARITY;
        R_PARITY: state_d = R_STOP;
        R_STOP: begin
          state_d = R_IDLE;
          if (bit_in) begin
`ifdef KBD_PARITY_CHECK_EN
            code_vld = par_ok;
            par_err  = ~par_ok;
`else
            code_vld = 1'b1;
`endif
          end
        end
        default:  state_d = R_IDLE;
      endcase
    end else if (timeout) begin
      state_d = R_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
      state_q   <= R_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      timer     <= '0;
`ifdef KBD_PARITY_CHECK_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
      state_q   <= state_d;
      timer     <= (state_q == R_IDLE || fall) ? '0 : timer + 1'b1;
      if (fall) begin
        case (state_q)
          R_IDLE: bit_cnt <= '0;
          R_DATA: begin
            shift   <= {bit_in, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
`ifdef KBD_PARITY_CHECK_EN
          R_PARITY: parity_q <= bit_in;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/kbd_io_slave.sv
// Memory-mapped PS/2 keyboard slave: receiver -> scan-code FIFO -> registers with one wait state.
// Define KBD_PARITY_CHECK_EN to drop bad-parity frames and report them in STATUS.perr.
module kbd_io_slave
  import kbd_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int          DEPTH     = 8,
  parameter int          TIMEOUT   = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  input  logic        we,
  input  logic        stb,
  output logic [31:0] data_o,
  output logic        ack,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  rx_code;
  logic        rx_vld, rx_perr;

  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .code     (rx_code),
    .code_vld (rx_vld),
    .par_err  (rx_perr)
  );

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        empty, full, push, pop, ovf, perr, ovf_set, clr_ovf, clr_perr;
  logic        sel, req, accept;
  logic [1:0]  off;
  logic [31:0] rd_word, status_word;
  bus_state_t  bus_q, bus_d;
  logic        unused_bits;

  assign unused_bits = ^{addr[1:0], data_i[31:2]};

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW + 1)'(DEPTH));
  assign irq   = ~empty;

  assign sel    = (addr[31:4] == BASE_ADDR[31:4]);
  assign req    = sel & (stb | we);
  assign accept = (bus_q == B_IDLE) & req;
  assign off    = addr[3:2];
  assign ack    = (bus_q == B_ACK);

  // A write strobe wins over a simultaneous read strobe.
  assign pop      = accept & ~we & (off == REG_DATA) & ~empty;
  assign push     = rx_vld & (~full | pop);
  assign ovf_set  = rx_vld & full & ~pop;
  assign clr_ovf  = accept & we & (off == REG_STATUS) & data_i[CLR_OVF_BIT];
  assign clr_perr = accept & we & (off == REG_STATUS) & data_i[CLR_PERR_BIT];

  always_comb begin
    status_word              = '0;
    status_word[3:0]         = 4'(count);
    status_word[ST_OVF_BIT]  = ovf;
    status_word[ST_PERR_BIT] = perr;
    case (off)
      REG_DATA:   rd_word = empty ? '0 : {23'b0, 1'b1, mem[rd_ptr[AW-1:0]]};
      REG_STATUS: rd_word = status_word;
      default:    rd_word = '0;
    endcase
  end

  always_comb begin
    bus_d = bus_q;
    case (bus_q)
      B_IDLE:  if (req) bus_d = B_ACK;
      B_ACK:   bus_d = B_IDLE;
      default: bus_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q  <= B_IDLE;
      data_o <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      perr   <= 1'b0;
    end else begin
      bus_q <= bus_d;
      if (accept && !we) data_o <= rd_word;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Set has priority over a same-cycle clear.
      ovf  <= ovf_set | (ovf & ~clr_ovf);
      perr <= rx_perr | (perr & ~clr_perr);
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_code;
  end

endmodule

// File: tb/tb_kbd_io_slave.sv
// Self-checking bench for kbd_io_slave: directed scenarios plus randomized frames vs. a queue model.
module tb_kbd_io_slave;

  localparam logic [31:0] BASE       = 32'hFFFF_FF00;
  localparam int          DEPTH      = 8;
  localparam int          TB_TIMEOUT = 200;
`ifdef KBD_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, we, stb, ps2_clk, ps2_data;
  logic [31:0] addr, data_i;
  logic [31:0] data_o;
  logic        ack, irq;

  kbd_io_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data_i   (data_i),
    .we       (we),
    .stb      (stb),
    .data_o   (data_o),
    .ack      (ack),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_perr = 1'b0;
  logic [31:0] d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {26'b0, m_perr, m_ovf, 4'(mq.size())};
  endfunction

  task automatic ps2_bit(input logic b);
    @(posedge clk); #1 ps2_data = b;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (8) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_head(input logic [7:0] code, input bit bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ bad_par);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    send_head(code, bad_par);
    ps2_bit(~bad_stop);
    if (!bad_stop) begin
      if (bad_par && PCHK)         m_perr = 1'b1;
      else if (mq.size() == DEPTH) m_ovf = 1'b1;
      else                         mq.push_back(code);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic bus_xfer(input logic [3:0] off, input logic s, input logic w,
                          input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    check("ack_before_req", {31'b0, ack}, 32'd0);
    addr = BASE | {28'b0, off}; stb = s; we = w; data_i = wd;
    @(posedge clk);
    @(negedge clk);
    check("ack_next_cycle", {31'b0, ack}, 32'd1);
    rd = data_o;
    @(posedge clk); #1 stb = 1'b0; we = 1'b0; data_i = '0;
    @(negedge clk);
    check("ack_one_cycle", {31'b0, ack}, 32'd0);
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] r, e;
    bus_xfer(4'h0, 1'b1, 1'b0, '0, r);
    if (mq.size() == 0) e = '0;
    else                e = {23'b0, 1'b1, mq.pop_front()};
    check(tag, r, e);
  endtask

  task automatic rd_status(input string tag);
    logic [31:0] r;
    bus_xfer(4'h4, 1'b1, 1'b0, '0, r);
    check(tag, r, exp_status());
  endtask

  task automatic wr_status(input logic [31:0] v);
    logic [31:0] r;
    bus_xfer(4'h4, 1'b0, 1'b1, v, r);
    if (v[0]) m_ovf = 1'b0;
    if (v[1]) m_perr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    stb = 1'b0; we = 1'b0; addr = '0; data_i = '0;
    #1;
    check("reset_ack", {31'b0, ack}, 32'd0);
    check("reset_irq", {31'b0, irq}, 32'd0);
    check("reset_data_o", data_o, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single good frame, read back and drain.
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t1_irq", {31'b0, irq}, 32'd1);
    rd_status("t1_status_1");
    bus_xfer(4'h0, 1'b1, 1'b0, '0, d);
    check("t1_data", d, 32'h0000_011C);
    void'(mq.pop_front());
    rd_status("t1_status_0");

    // Empty read, reserved register, unmapped address.
    rd_data("t2_empty_data");
    rd_status("t2_status");
    bus_xfer(4'h8, 1'b1, 1'b0, '0, d);
    check("t2_reg2", d, 32'd0);
    @(negedge clk); addr = 32'h0000_0000; stb = 1'b1;
    repeat (2) @(negedge clk);
    check("t2_unmapped_no_ack", {31'b0, ack}, 32'd0);
    @(posedge clk); #1 stb = 1'b0;

    // Overflow on 9 frames, clear ovf, drain in order.
    for (int i = 0; i < 9; i++) send_frame(8'(8'h40 + i), 1'b0, 1'b0);
    bus_xfer(4'h4, 1'b1, 1'b0, '0, d);
    check("t3_status_full", d, 32'h18);
    check("t3_status_model", d, exp_status());
    wr_status(32'h1);
    rd_status("t3_status_cleared");
    while (mq.size() > 0) rd_data("t3_drain");

    // Bad parity frame.
    send_frame(8'h55, 1'b1, 1'b0);
    rd_status("t4_status");
    rd_data("t4_data");
    wr_status(32'h2);
    rd_status("t4_status_cleared");

    // stb and we together is a write: no pop.
    send_frame(8'h77, 1'b0, 1'b0);
    bus_xfer(4'h0, 1'b1, 1'b1, '0, d);
    rd_status("both_strobes_no_pop");
    rd_data("both_strobes_data");

    // Aborted frame via timeout, then a clean frame.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TB_TIMEOUT + 1) @(posedge clk);
    send_frame(8'h2A, 1'b0, 1'b0);
    rd_status("t5_status");
    rd_data("t5_data");

    // Randomized frames and accesses.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      bit bp, bs;
      b  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 7) == 0);
      send_frame(b, bp, bs);
      check("rand_irq", {31'b0, irq}, {31'b0, mq.size() != 0});
      if ($urandom_range(0, 1) == 1) rd_data("rand_data");
      if ($urandom_range(0, 3) == 0) rd_status("rand_status");
    end

    // Simultaneous pop and push with the FIFO full.
    while (mq.size() > 0) rd_data("t6_predrain");
    wr_status(32'h3);
    for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h60 + i), 1'b0, 1'b0);
    rd_status("t6_full");
    send_head(8'h5A, 1'b0);
    @(posedge clk); #1 ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); addr = BASE; stb = 1'b1; we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_ack", {31'b0, ack}, 32'd1);
    check("t6_pop_data", data_o, {23'b0, 1'b1, mq.pop_front()});
    mq.push_back(8'h5A);
    @(posedge clk); #1 stb = 1'b0;
    repeat (6) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (8) @(posedge clk);
    rd_status("t6_status_after");
    while (mq.size() > 0) rd_data("t6_drain");

    // Reset mid-frame and mid-ack.
    send_frame(8'h11, 1'b0, 1'b0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    @(negedge clk); addr = BASE | 32'h4; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6r_ack_before_reset", {31'b0, ack}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t6r_ack", {31'b0, ack}, 32'd0);
    check("t6r_irq", {31'b0, irq}, 32'd0);
    check("t6r_data_o", data_o, 32'd0);
    mq.delete(); m_ovf = 1'b0; m_perr = 1'b0;
    @(posedge clk); #1 stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rd_status("t6r_status");
    send_frame(8'h33, 1'b0, 1'b0);
    rd_data("t6r_after_reset_data");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
